pipe_flow_ctrl: RTL and testbench

PIPE_FLOW_CTRL -- requirements
Module: pipe_flow_ctrl

---
 rtl/pipe_pkg.sv | 15 +
 rtl/pipe_flow_ctrl_sat_cnt.sv | 28 ++
 rtl/pipe_flow_ctrl.sv | 124 ++++++++++++
 tb/tb_pipe_flow_ctrl.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types and defaults for the fetch-stage flow controller.
// Holds FSM encoding, reset/nop words and counter width.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_HOLD  = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;

    localparam logic [31:0] NOP_INST_D = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_D = 32'h0000_3000;
    localparam int          CNT_W      = 16;

endpackage

// File: rtl/pipe_flow_ctrl_sat_cnt.sv
// Saturating up-counter with synchronous clear.
// Sticks at all-ones instead of wrapping.
module sat_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_inc,
    input  logic         i_clr,
    output logic [W-1:0] o_cnt
);

    logic [W-1:0] r_cnt;

    // count up on inc, hold at max, clear on request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != {W{1'b1}})) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/pipe_flow_ctrl.sv
// Fetch PC and IF/ID register control: hold, redirect, advance.
// Also tracks stall/flush statistics and long-hold errors.
module pipe_flow_ctrl
    import pipe_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_D,
    parameter logic [31:0] NOP_INST = NOP_INST_D
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_use,
    input  logic        branch_hd,
    input  logic        redirect,
    input  logic [31:0] npc,
    input  logic [31:0] imem_inst,
    output logic [31:0] pc,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_inst,
    output logic        if_id_valid,
    output logic        id_ex_bubble,
    output logic [1:0]  state,
    output logic [15:0] stall_cycles,
    output logic [15:0] flush_count,
    output logic        hazard_err
);

    logic        w_hold;
    logic        w_flush;
    logic [31:0] w_pc_inc;
    logic [31:0] r_pc;
    logic [31:0] r_if_id_pc;
    logic [31:0] r_if_id_inst;
    logic        r_if_id_valid;
    state_e      r_state;
    state_e      w_state_nxt;
    logic [1:0]  r_hold_cnt;
    logic        r_hazard_err;

    assign w_hold   = load_use | branch_hd;
    assign w_flush  = redirect & ~w_hold;
    assign w_pc_inc = r_pc + 32'd4;

    // PC and IF/ID: hold beats redirect beats advance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc          <= RESET_PC;
            r_if_id_pc    <= 32'd0;
            r_if_id_inst  <= NOP_INST;
            r_if_id_valid <= 1'b0;
        end else if (w_hold) begin
            r_pc          <= r_pc;
        end else if (redirect) begin
            r_pc          <= npc;
            r_if_id_pc    <= w_pc_inc;
            r_if_id_inst  <= NOP_INST;
            r_if_id_valid <= 1'b0;
        end else begin
            r_pc          <= w_pc_inc;
            r_if_id_pc    <= w_pc_inc;
            r_if_id_inst  <= imem_inst;
            r_if_id_valid <= 1'b1;
        end
    end

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // next state depends only on this cycle's requests
    always_comb begin
        w_state_nxt = ST_RUN;
        if (w_hold) begin
            w_state_nxt = ST_HOLD;
        end else if (redirect) begin
            w_state_nxt = ST_FLUSH;
        end
    end

    // consecutive-hold run length and sticky overrun flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold_cnt   <= 2'd0;
            r_hazard_err <= 1'b0;
        end else if (w_hold) begin
            if (r_hold_cnt == 2'd3) begin
                r_hazard_err <= 1'b1;
            end else begin
                r_hold_cnt <= r_hold_cnt + 2'd1;
            end
        end else begin
            r_hold_cnt <= 2'd0;
        end
    end

    sat_cnt #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .i_inc (w_hold),
        .i_clr (1'b0),
        .o_cnt (stall_cycles)
    );

    sat_cnt #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .i_inc (w_flush),
        .i_clr (1'b0),
        .o_cnt (flush_count)
    );

    assign pc           = r_pc;
    assign if_id_pc     = r_if_id_pc;
    assign if_id_inst   = r_if_id_inst;
    assign if_id_valid  = r_if_id_valid;
    assign id_ex_bubble = w_hold;
    assign state        = r_state;
    assign hazard_err   = r_hazard_err;

endmodule

// File: tb/tb_pipe_flow_ctrl.sv
// Bench for pipe_flow_ctrl: directed scenarios plus random
// traffic against a transaction-level reference model.
module tb_pipe_flow_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load_use;
    logic        branch_hd;
    logic        redirect;
    logic [31:0] npc;
    logic [31:0] imem_inst;
    logic [31:0] pc;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_inst;
    logic        if_id_valid;
    logic        id_ex_bubble;
    logic [1:0]  state;
    logic [15:0] stall_cycles;
    logic [15:0] flush_count;
    logic        hazard_err;

    int n_total = 0;
    int n_bad   = 0;
    bit fixed_imem;

    logic [31:0] m_pc;
    logic [31:0] m_ifpc;
    logic [31:0] m_inst;
    logic        m_valid;
    logic        m_err;
    int          m_state;
    int          m_stall;
    int          m_flush;
    int          m_run;

    always #5 clk = ~clk;

    pipe_flow_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .load_use     (load_use),
        .branch_hd    (branch_hd),
        .redirect     (redirect),
        .npc          (npc),
        .imem_inst    (imem_inst),
        .pc           (pc),
        .if_id_pc     (if_id_pc),
        .if_id_inst   (if_id_inst),
        .if_id_valid  (if_id_valid),
        .id_ex_bubble (id_ex_bubble),
        .state        (state),
        .stall_cycles (stall_cycles),
        .flush_count  (flush_count),
        .hazard_err   (hazard_err)
    );

    function automatic logic [31:0] imem_f(input logic [31:0] a);
        if (fixed_imem) return 32'h2008_0005;
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    assign imem_inst = imem_f(pc);

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_pc    = 32'h0000_3000;
        m_ifpc  = 32'd0;
        m_inst  = 32'd0;
        m_valid = 1'b0;
        m_err   = 1'b0;
        m_state = 0;
        m_stall = 0;
        m_flush = 0;
        m_run   = 0;
    endtask

    // one clock edge of the pipeline, described by its rules
    task automatic m_edge(input logic lu, input logic bh,
                          input logic rd, input logic [31:0] np);
        if (lu || bh) begin
            if (m_run >= 3) m_err = 1'b1;
            m_run = m_run + 1;
            if (m_stall < 65535) m_stall = m_stall + 1;
            m_state = 1;
        end else if (rd) begin
            m_ifpc  = m_pc + 32'd4;
            m_pc    = np;
            m_inst  = 32'd0;
            m_valid = 1'b0;
            if (m_flush < 65535) m_flush = m_flush + 1;
            m_state = 2;
            m_run   = 0;
        end else begin
            m_inst  = imem_f(m_pc);
            m_pc    = m_pc + 32'd4;
            m_ifpc  = m_pc;
            m_valid = 1'b1;
            m_state = 0;
            m_run   = 0;
        end
    endtask

    task automatic check_all();
        chk("pc",     pc,                  m_pc);
        chk("ifpc",   if_id_pc,            m_ifpc);
        chk("inst",   if_id_inst,          m_inst);
        chk("valid",  {31'd0, if_id_valid}, {31'd0, m_valid});
        chk("state",  {30'd0, state},      m_state);
        chk("stall",  {16'd0, stall_cycles}, m_stall);
        chk("flush",  {16'd0, flush_count},  m_flush);
        chk("hz_err", {31'd0, hazard_err}, {31'd0, m_err});
    endtask

    task automatic step(input logic lu, input logic bh,
                        input logic rd, input logic [31:0] np,
                        input bit do_chk);
        @(negedge clk);
        load_use  = lu;
        branch_hd = bh;
        redirect  = rd;
        npc       = np;
        #1;
        if (do_chk) chk("bubble", {31'd0, id_ex_bubble}, {31'd0, lu | bh});
        @(posedge clk);
        m_edge(lu, bh, rd, np);
        #1;
        if (do_chk) check_all();
    endtask

    initial begin
        rst_n      = 1'b0;
        load_use   = 1'b0;
        branch_hd  = 1'b0;
        redirect   = 1'b0;
        npc        = 32'd0;
        fixed_imem = 1'b1;
        m_reset();
        #12;
        check_all();
        @(posedge clk);
        #1 rst_n = 1'b1;

        // straight-line fetch
        repeat (3) step(0, 0, 0, 32'd0, 1);
        chk("pc_300c", pc, 32'h0000_300C);
        chk("inst_fix", if_id_inst, 32'h2008_0005);

        // single load-use stall, then resume
        step(1, 0, 0, 32'd0, 1);
        step(0, 0, 0, 32'd0, 1);

        // redirect flush
        step(0, 0, 1, 32'h0000_3040, 1);
        chk("pc_3040", pc, 32'h0000_3040);

        // branch operand wait blocks redirect, then it lands
        step(0, 1, 1, 32'h0000_3080, 1);
        step(0, 1, 1, 32'h0000_3080, 1);
        step(0, 0, 1, 32'h0000_3080, 1);
        chk("pc_3080", pc, 32'h0000_3080);

        // long load-use hold trips the sticky error
        repeat (5) step(1, 0, 0, 32'd0, 1);
        chk("err_set", {31'd0, hazard_err}, 32'd1);
        repeat (2) step(0, 0, 0, 32'd0, 1);
        chk("err_stk", {31'd0, hazard_err}, 32'd1);

        // pc wrap at top of address space
        step(0, 0, 1, 32'hFFFF_FFFC, 1);
        step(0, 0, 0, 32'd0, 1);
        chk("pc_wrap", pc, 32'd0);

        // random traffic
        fixed_imem = 1'b0;
        for (int i = 0; i < 400; i++) begin
            step(($urandom % 5) == 0, ($urandom % 6) == 0,
                 ($urandom % 4) == 0, $urandom, 1);
        end

        // stall counter saturation
        for (int i = 0; i < 65540; i++) begin
            step(1, 0, 0, 32'd0, 0);
        end
        check_all();
        chk("stall_sat", {16'd0, stall_cycles}, 32'h0000_FFFF);

        // asynchronous reset in the middle of a hold
        #2 rst_n = 1'b0;
        #1;
        m_reset();
        check_all();
        chk("bub_rst1", {31'd0, id_ex_bubble}, 32'd1);
        load_use = 1'b0;
        #1;
        chk("bub_rst0", {31'd0, id_ex_bubble}, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        step(0, 0, 0, 32'd0, 1);
        step(0, 0, 1, 32'h0000_4000, 1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
